joystick_adc_reader: RTL and testbench

//  Serial-ADC master that samples the two joystick axes and feeds the speed controller.

---
 rtl/joystick_adc_reader_pkg.sv | 22 ++
 rtl/joystick_adc_reader_if.sv | 20 ++
 rtl/joystick_adc_reader_shift.sv | 65 ++++++
 rtl/joystick_adc_reader.sv | 135 +++++++++++++
 tb/tb_joystick_adc_reader.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/joystick_adc_reader_pkg.sv
// Shared constants and types for the joystick ADC reader.
package joystick_adc_reader_pkg;

  // {S/D, O/S, S1, S0, UNI, SLP}: single-ended, unipolar, awake
  localparam logic [5:0]  ADC_CFG_CH0  = 6'b100010;
  localparam logic [5:0]  ADC_CFG_CH1  = 6'b100110;
  // Top byte 0x32 is read by the speed controller as stop/hold
  localparam logic [15:0] NEUTRAL_DATA = 16'h3200;

  typedef enum logic [2:0] {
    IDLE,
    CONVST,
    WAIT_CONV,
    SHIFT,
    LATCH
  } state_t;

  function automatic logic [5:0] adc_cfg_word(input logic ch);
    return ch ? ADC_CFG_CH1 : ADC_CFG_CH0;
  endfunction

endpackage

// File: rtl/joystick_adc_reader_if.sv
// ADC pins plus the published {channel, data} pair with its update strobe.
interface joystick_adc_reader_if;
  logic        o_adc_convst;
  logic        o_adc_sck;
  logic        o_adc_sdi;
  logic        i_adc_sdo;
  logic        o_channel;
  logic [15:0] o_data;
  logic        o_valid;

  modport master (
    output o_adc_convst, o_adc_sck, o_adc_sdi, o_channel, o_data, o_valid,
    input  i_adc_sdo
  );

  modport slave (
    input  o_adc_convst, o_adc_sck, o_adc_sdi, o_channel, o_data, o_valid,
    output i_adc_sdo
  );
endinterface

// File: rtl/joystick_adc_reader_shift.sv
// Full-duplex MSB-first shifter; each bit is CLK_DIV cycles sck low then CLK_DIV high.
module joystick_adc_reader_shift #(
  parameter int CLK_DIV  = 2,
  parameter int ADC_BITS = 12
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                start,
  input  logic [ADC_BITS-1:0] tx_word,
  output logic                done,
  output logic [ADC_BITS-1:0] rx_word,
  output logic                sck,
  output logic                sdi,
  input  logic                sdo
);

  localparam int DIV_W = $clog2(2 * CLK_DIV);
  localparam int BIT_W = (ADC_BITS > 1) ? $clog2(ADC_BITS) : 1;
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(ADC_BITS - 1);

  logic                busy;
  logic [DIV_W-1:0]    div_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [ADC_BITS-1:0] tx_sr;
  logic [ADC_BITS-1:0] rx_sr;

  // sck and sdi are gated by busy so both sit low outside a transfer
  assign sck     = busy && (div_cnt >= DIV_HALF);
  assign sdi     = busy && tx_sr[ADC_BITS-1];
  assign done    = busy && (div_cnt == DIV_LAST) && (bit_cnt == BIT_LAST);
  assign rx_word = rx_sr;

  // Bit timing: sample sdo on the sck rising cycle, advance tx at the end of each bit
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
    end else if (start) begin
      busy    <= 1'b1;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sr   <= tx_word;
      rx_sr   <= '0;
    end else if (busy) begin
      if (div_cnt == DIV_HALF) rx_sr <= {rx_sr[ADC_BITS-2:0], sdo};
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        if (bit_cnt == BIT_LAST) begin
          busy <= 1'b0;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
          tx_sr   <= {tx_sr[ADC_BITS-2:0], 1'b0};
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/joystick_adc_reader.sv
// Joystick ADC reader: frames the LTC2308 conversions and publishes {channel, data}.
//
//  state     | meaning
//  IDLE      | waiting for the frame period to expire with i_enable high
//  CONVST    | convst high, two cycles
//  WAIT_CONV | conversion time, CONV_CYCLES cycles
//  SHIFT     | config out / result in over SPI
//  LATCH     | one cycle; published pair visible with o_valid if primed
module joystick_adc_reader
  import joystick_adc_reader_pkg::*;
#(
  parameter int CLK_DIV      = 2,
  parameter int CONV_CYCLES  = 80,
  parameter int FRAME_CYCLES = 2500,
  parameter int ADC_BITS     = 12
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_enable,
  joystick_adc_reader_if.master  bus
);

  localparam int FRAME_LEN = 2 + CONV_CYCLES + 2 * CLK_DIV * ADC_BITS + 1;
  localparam int FRAME_EFF = (FRAME_CYCLES > FRAME_LEN) ? FRAME_CYCLES : FRAME_LEN;
  localparam int PER_W     = $clog2(FRAME_EFF);
  localparam int WAIT_W    = (CONV_CYCLES > 2) ? $clog2(CONV_CYCLES) : 1;
  localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(FRAME_EFF - 1);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(CONV_CYCLES - 1);

  state_t              state, state_nxt;
  logic [WAIT_W-1:0]   tmr;
  logic [PER_W-1:0]    per_cnt;
  logic                cfg_ch, last_ch, prime;
  logic                convst, shift_start, shift_done;
  logic                tmr_zero, go, enter_frame;
  logic [ADC_BITS-1:0] tx_word, rx_word;
  logic                channel_q, valid_q;
  logic [15:0]         data_q;

  assign tmr_zero    = (tmr == '0);
  assign go          = (per_cnt == PER_LAST) && i_enable;
  assign enter_frame = ((state == IDLE) || (state == LATCH)) && go;
  assign tx_word     = {adc_cfg_word(cfg_ch), {(ADC_BITS-6){1'b0}}};

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state; LATCH may chain straight into CONVST when the period is shorter than a frame
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (go)         state_nxt = CONVST;
      CONVST:    if (tmr_zero)   state_nxt = WAIT_CONV;
      WAIT_CONV: if (tmr_zero)   state_nxt = SHIFT;
      SHIFT:     if (shift_done) state_nxt = LATCH;
      LATCH:     state_nxt = go ? CONVST : IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    convst      = (state == CONVST);
    shift_start = (state == WAIT_CONV) && tmr_zero;
  end

  // Down-counter for the CONVST pulse and the conversion wait
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                         tmr <= '0;
    else if (enter_frame)                 tmr <= WAIT_W'(1);
    else if (state == CONVST && tmr_zero) tmr <= WAIT_LOAD;
    else if (!tmr_zero)                   tmr <= tmr - 1'b1;
  end

  // Period counter tracks frame time t from CONVST and parks at the last value
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                  per_cnt <= PER_LAST;
    else if (enter_frame)          per_cnt <= '0;
    else if (per_cnt != PER_LAST)  per_cnt <= per_cnt + 1'b1;
  end

  // Channel alternates every frame; prime survives only while enabled
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cfg_ch  <= 1'b0;
      last_ch <= 1'b0;
      prime   <= 1'b0;
    end else if (state == LATCH) begin
      cfg_ch  <= ~cfg_ch;
      last_ch <= cfg_ch;
      prime   <= i_enable;
    end else if (state == IDLE && !i_enable) begin
      prime   <= 1'b0;
    end
  end

  // Published pair loads atomically on entry to LATCH so o_valid marks fresh data
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      channel_q <= 1'b0;
      data_q    <= NEUTRAL_DATA;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= shift_done && prime;
      if (shift_done && prime) begin
        channel_q <= last_ch;
        data_q    <= {rx_word, {(16-ADC_BITS){1'b0}}};
      end
    end
  end

  joystick_adc_reader_shift #(
    .CLK_DIV  (CLK_DIV),
    .ADC_BITS (ADC_BITS)
  ) u_shift (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .start   (shift_start),
    .tx_word (tx_word),
    .done    (shift_done),
    .rx_word (rx_word),
    .sck     (bus.o_adc_sck),
    .sdi     (bus.o_adc_sdi),
    .sdo     (bus.i_adc_sdo)
  );

  assign bus.o_adc_convst = convst;
  assign bus.o_channel    = channel_q;
  assign bus.o_data       = data_q;
  assign bus.o_valid      = valid_q;

endmodule

// File: tb/tb_joystick_adc_reader.sv
// Bench for joystick_adc_reader with a behavioural LTC2308 and a frame-level reference.
module tb_joystick_adc_reader;

  logic clk = 1'b0;
  logic rst_n;
  logic enable;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  joystick_adc_reader_if adc_if();

  joystick_adc_reader dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_enable(enable),
    .bus     (adc_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural ADC ----------------
  logic [11:0] code [2];
  logic [5:0]  cfg_latched = 6'b100010;
  logic [5:0]  cfg_sr = 6'b0;
  int          cfg_bits = 0;
  logic [11:0] sdo_sr = 12'h0;

  always @(posedge adc_if.o_adc_convst or posedge adc_if.o_adc_sck or negedge adc_if.o_adc_sck) begin
    if (adc_if.o_adc_convst) begin
      sdo_sr   = code[cfg_latched[2]];
      cfg_bits = 0;
    end else if (adc_if.o_adc_sck) begin
      if (cfg_bits < 6) begin
        cfg_sr   = {cfg_sr[4:0], adc_if.o_adc_sdi};
        cfg_bits = cfg_bits + 1;
        if (cfg_bits == 6) cfg_latched = cfg_sr;
      end
    end else begin
      sdo_sr = {sdo_sr[10:0], 1'b0};
    end
  end
  assign adc_if.i_adc_sdo = sdo_sr[11];

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit          started;
    int          start_cyc;
    int          convst_hi;
    int          convst_late;
    int          sck_pulses;
    int          sck_hi;
    int          first_rise;
    int          last_rise;
    logic [11:0] cfg;
    int          valid_cnt;
    int          valid_t;
    logic        vch;
    logic [15:0] vdata;
    logic [15:0] data_t0;
  } obs_t;

  // Observe one frame (t=0 is the first convst-high cycle), optionally dropping
  // enable or pulsing reset at a given t.
  task automatic run_frame(input int drop_t, input int rst_t, output obs_t o);
    logic ps;
    int   n;
    o = '{default: 0};
    o.first_rise = -1;
    n = 0;
    @(negedge clk);
    while (!adc_if.o_adc_convst && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!adc_if.o_adc_convst) return;
    o.started   = 1;
    o.start_cyc = cyc;
    o.data_t0   = adc_if.o_data;
    ps = 1'b0;
    for (int t = 0; t < 140; t++) begin
      if (t > 0) @(negedge clk);
      if (adc_if.o_adc_convst) begin
        if (t < 2) o.convst_hi++;
        else       o.convst_late++;
      end
      if (adc_if.o_adc_sck && !ps) begin
        o.sck_pulses++;
        o.cfg = {o.cfg[10:0], adc_if.o_adc_sdi};
        if (o.first_rise < 0) o.first_rise = t;
        o.last_rise = t;
      end
      if (adc_if.o_adc_sck) o.sck_hi++;
      ps = adc_if.o_adc_sck;
      if (adc_if.o_valid) begin
        o.valid_cnt++;
        o.valid_t = t;
        o.vch     = adc_if.o_channel;
        o.vdata   = adc_if.o_data;
      end
      if (t == drop_t) enable = 1'b0;
      if (t == rst_t) begin
        rst_n = 1'b0;
        #1;
        chk("rst_mid_sck", adc_if.o_adc_sck, 0);
        chk("rst_mid_convst", adc_if.o_adc_convst, 0);
        chk("rst_mid_data", adc_if.o_data, 16'h3200);
        chk("rst_mid_valid", adc_if.o_valid, 0);
      end
    end
  endtask

  // ---------------- frame-level reference ----------------
  int          fidx;
  bit          primed;
  bit          have_prev;
  int          prev_start;
  logic [15:0] last_pub;

  task automatic ref_reset();
    fidx = 0; primed = 0; have_prev = 0; last_pub = 16'h3200;
  endtask

  task automatic frame_and_check(input int drop_t, output obs_t o);
    logic        sent_ch, rd_ch;
    logic [11:0] exp_cfg;
    run_frame(drop_t, -1, o);
    chk("frame_start", o.started, 1);
    if (!o.started) return;
    sent_ch = 1'(fidx % 2);
    rd_ch   = 1'((fidx + 1) % 2);
    exp_cfg = {1'b1, 1'b0, 1'b0, sent_ch, 1'b1, 1'b0, 6'b0};
    chk("convst_width", o.convst_hi, 2);
    chk("convst_extra", o.convst_late, 0);
    chk("sck_pulses", o.sck_pulses, 12);
    chk("sck_high_cycles", o.sck_hi, 24);
    chk("sck_first_rise_t", o.first_rise, 84);
    chk("sck_last_rise_t", o.last_rise, 128);
    chk("cfg_word", o.cfg, exp_cfg);
    chk("data_held", o.data_t0, last_pub);
    chk("valid_count", o.valid_cnt, primed ? 1 : 0);
    if (primed) begin
      chk("valid_t", o.valid_t, 130);
      chk("pub_channel", o.vch, rd_ch);
      chk("pub_data", o.vdata, {code[rd_ch], 4'b0});
      last_pub = {code[rd_ch], 4'b0};
    end
    if (have_prev) chk("convst_period", o.start_cyc - prev_start, 2500);
    prev_start = o.start_cyc;
    have_prev  = enable;
    primed     = enable;
    fidx++;
  endtask

  typedef struct {
    logic [11:0] c0;
    logic [11:0] c1;
    bit          exp_valid;
    logic        exp_ch;
    logic [15:0] exp_data;
    logic [11:0] exp_cfg;
  } vec_t;

  vec_t vecs [5];
  obs_t ob;
  int   n_hi;

  initial begin
    vecs[0] = '{12'hABC, 12'h123, 1'b0, 1'b0, 16'h0000, 12'h880};
    vecs[1] = '{12'hABC, 12'h123, 1'b1, 1'b0, 16'hABC0, 12'h980};
    vecs[2] = '{12'hABC, 12'h123, 1'b1, 1'b1, 16'h1230, 12'h880};
    vecs[3] = '{12'h000, 12'hFFF, 1'b1, 1'b0, 16'h0000, 12'h980};
    vecs[4] = '{12'h5A5, 12'hFFF, 1'b1, 1'b1, 16'hFFF0, 12'h880};

    code[0] = 12'hABC;
    code[1] = 12'h123;
    rst_n  = 1'b0;
    enable = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_sck", adc_if.o_adc_sck, 0);
    chk("reset_convst", adc_if.o_adc_convst, 0);
    chk("reset_sdi", adc_if.o_adc_sdi, 0);
    chk("reset_channel", adc_if.o_channel, 0);
    chk("reset_data", adc_if.o_data, 16'h3200);
    chk("reset_valid", adc_if.o_valid, 0);
    ref_reset();
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 5; i++) begin
      code[0] = vecs[i].c0;
      code[1] = vecs[i].c1;
      frame_and_check(-1, ob);
      chk("tbl_valid", ob.valid_cnt, vecs[i].exp_valid ? 1 : 0);
      chk("tbl_cfg", ob.cfg, vecs[i].exp_cfg);
      if (vecs[i].exp_valid) begin
        chk("tbl_channel", ob.vch, vecs[i].exp_ch);
        chk("tbl_data", ob.vdata, vecs[i].exp_data);
      end
    end

    // Random codes against the reference
    for (int i = 0; i < 8; i++) begin
      code[0] = 12'($urandom_range(0, 4095));
      code[1] = 12'($urandom_range(0, 4095));
      frame_and_check(-1, ob);
    end

    // Drop enable during SHIFT: frame still publishes, then nothing
    code[0] = 12'h777;
    code[1] = 12'h0F1;
    frame_and_check(int'($urandom_range(82, 129)), ob);
    chk("drop_frame_published", ob.valid_cnt, 1);
    n_hi = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (adc_if.o_adc_convst) n_hi++;
    end
    chk("no_convst_disabled", n_hi, 0);
    enable = 1'b1;
    frame_and_check(-1, ob);
    chk("reenable_silent", ob.valid_cnt, 0);
    frame_and_check(-1, ob);
    chk("reenable_publish", ob.valid_cnt, 1);

    // Reset pulse mid-SHIFT with sck high
    run_frame(-1, 82 + 4 * int'($urandom_range(0, 11)) + 2, ob);
    chk("rst_frame_started", ob.started, 1);
    @(negedge clk);
    ref_reset();
    rst_n = 1'b1;
    code[0] = 12'h246;
    code[1] = 12'h9DB;
    frame_and_check(-1, ob);
    chk("post_rst_silent", ob.valid_cnt, 0);
    frame_and_check(-1, ob);
    chk("post_rst_publish", ob.valid_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
